// File: rtl/apb_reg_slave.sv
// APB3 completer holding NUM_REGS byte-strobed data registers and a sticky
// STATUS register (EVT/ERR, W1C) that drives a level interrupt.
module apb_reg_slave #(
   parameter logic [31:0] BASE_ADDR   = 32'h10,
   parameter int          NUM_REGS    = 4,
   parameter int          WAIT_STATES = 0
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PADDR,
   input  logic [31:0] PWDATA,
   input  logic [3:0]  PSTRB,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   input  logic        event_in,
   output logic        irq,
   output logic        o_dbg_state
);

   // Handshake: a transfer is offered by PSEL=1,PENABLE=0 (setup) and held
   // with PENABLE=1; it completes in the single cycle where PREADY=1, and
   // PRDATA/PSLVERR are meaningful only in that cycle (0 otherwise).
   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   state_t       r_state;
   state_t       w_state_nxt;
   logic [3:0]   r_cnt;
   logic [3:0]   w_cnt_nxt;

   logic [31:0]  r_data [NUM_REGS];
   logic [1:0]   r_status;

   logic [29:0]  w_word;
   logic         w_below;
   logic         w_above;
   logic         w_misal;
   logic         w_bad;
   logic         w_is_status;
   logic         w_complete;
   logic         w_wr_ok;
   logic [1:0]   w_clr;
   logic [1:0]   w_set;
   logic [31:0]  w_rdata;

   // Word index relative to data register 0; STATUS is word NUM_REGS.
   assign w_word      = PADDR[31:2] - BASE_ADDR[31:2];
   assign w_below     = (PADDR < BASE_ADDR);
   assign w_above     = (w_word > 30'(NUM_REGS));
   assign w_misal     = |PADDR[1:0];
   assign w_bad       = w_below | w_above | w_misal;
   assign w_is_status = (w_word == 30'(NUM_REGS));

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (PSEL && !PENABLE) begin
               w_state_nxt = ST_ACCESS;
               w_cnt_nxt   = 4'(WAIT_STATES);
            end
         end
         ST_ACCESS: begin
            // Dropping PSEL mid-access abandons the transfer silently.
            if (!PSEL) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt != 4'd0) begin
               w_cnt_nxt = r_cnt - 4'd1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign w_complete = (r_state == ST_ACCESS) && PSEL && (r_cnt == 4'd0);
   assign w_wr_ok    = w_complete && PWRITE && !w_bad;

   always_ff @(posedge aclk) begin
      if (areset) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            r_data[k] <= '0;
         end
      end else if (w_wr_ok) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            for (int b = 0; b < 4; b++) begin
               if ((w_word == 30'(k)) && PSTRB[b]) begin
                  r_data[k][8*b +: 8] <= PWDATA[8*b +: 8];
               end
            end
         end
      end
   end

   // Sets are ORed in after the clear so a coincident event or error wins.
   assign w_clr = (w_wr_ok && w_is_status && PSTRB[0]) ? PWDATA[1:0] : 2'b00;
   assign w_set = {w_complete && w_bad, event_in};

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_status <= '0;
      end else begin
         r_status <= (r_status & ~w_clr) | w_set;
      end
   end

   always_comb begin
      w_rdata = '0;
      if (w_is_status) begin
         w_rdata = {30'b0, r_status};
      end else begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (w_word == 30'(k)) begin
               w_rdata = r_data[k];
            end
         end
      end
   end

   assign PREADY      = w_complete;
   assign PSLVERR     = w_complete && w_bad;
   assign PRDATA      = (w_complete && !PWRITE && !w_bad) ? w_rdata : '0;
   assign irq         = |r_status;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: three instances with 0, 3 and 2 wait
// states, each on its own APB bus, checked against hand-computed values.
module tb_apb_reg_slave;

   logic        aclk;
   logic [2:0]  areset;
   logic [2:0]  psel;
   logic [2:0]  penable;
   logic [2:0]  pwrite;
   logic [31:0] paddr  [3];
   logic [31:0] pwdata [3];
   logic [3:0]  pstrb  [3];
   logic [2:0]  event_in;
   logic [31:0] prdata [3];
   logic [2:0]  pready;
   logic [2:0]  pslverr;
   logic [2:0]  irq;
   logic [2:0]  dbg_state;

   int n_total = 0;
   int n_bad   = 0;

   apb_reg_slave #(.BASE_ADDR(32'h10), .NUM_REGS(4), .WAIT_STATES(0)) u_ws0 (
      .aclk(aclk), .areset(areset[0]), .PSEL(psel[0]), .PENABLE(penable[0]),
      .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
      .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]),
      .event_in(event_in[0]), .irq(irq[0]), .o_dbg_state(dbg_state[0]));

   apb_reg_slave #(.BASE_ADDR(32'h10), .NUM_REGS(4), .WAIT_STATES(3)) u_ws3 (
      .aclk(aclk), .areset(areset[1]), .PSEL(psel[1]), .PENABLE(penable[1]),
      .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
      .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]),
      .event_in(event_in[1]), .irq(irq[1]), .o_dbg_state(dbg_state[1]));

   apb_reg_slave #(.BASE_ADDR(32'h10), .NUM_REGS(4), .WAIT_STATES(2)) u_ws2 (
      .aclk(aclk), .areset(areset[2]), .PSEL(psel[2]), .PENABLE(penable[2]),
      .PWRITE(pwrite[2]), .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PSTRB(pstrb[2]),
      .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]),
      .event_in(event_in[2]), .irq(irq[2]), .o_dbg_state(dbg_state[2]));

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called #1 after a rising edge; returns #1 after the completing edge.
   task automatic apb(input int idx, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb, input bit evt,
                      output logic [31:0] rd, output logic err, output int waits);
      psel[idx]    = 1'b1;
      penable[idx] = 1'b0;
      pwrite[idx]  = wr;
      paddr[idx]   = addr;
      pwdata[idx]  = wdata;
      pstrb[idx]   = strb;
      @(posedge aclk); #1;
      penable[idx] = 1'b1;
      waits = 0;
      while (!pready[idx] && waits < 40) begin
         chk("wait_prdata", prdata[idx], 32'h0);
         chk("wait_state", {31'b0, dbg_state[idx]}, 32'h1);
         @(posedge aclk); #1;
         waits++;
      end
      if (waits >= 40) chk("timeout", 32'h1, 32'h0);
      rd  = prdata[idx];
      err = pslverr[idx];
      if (evt) event_in[idx] = 1'b1;
      @(posedge aclk); #1;
      event_in[idx] = 1'b0;
      psel[idx]     = 1'b0;
      penable[idx]  = 1'b0;
   endtask

   task automatic wr_chk(input int idx, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int exp_waits, input string tag);
      logic [31:0] rd;
      logic        err;
      int          waits;
      apb(idx, 1'b1, addr, data, strb, 1'b0, rd, err, waits);
      chk({tag, "_err"}, {31'b0, err}, 32'h0);
      chk({tag, "_waits"}, waits, exp_waits);
   endtask

   task automatic rd_chk(input int idx, input logic [31:0] addr, input logic [31:0] exp,
                         input int exp_waits, input string tag);
      logic [31:0] rd;
      logic        err;
      int          waits;
      apb(idx, 1'b0, addr, 32'h0, 4'h0, 1'b0, rd, err, waits);
      chk(tag, rd, exp);
      chk({tag, "_err"}, {31'b0, err}, 32'h0);
      chk({tag, "_waits"}, waits, exp_waits);
   endtask

   task automatic bad_chk(input int idx, input bit wr, input logic [31:0] addr, input string tag);
      logic [31:0] rd;
      logic        err;
      int          waits;
      apb(idx, wr, addr, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, err, waits);
      chk({tag, "_err"}, {31'b0, err}, 32'h1);
      chk({tag, "_rd"}, rd, 32'h0);
   endtask

   initial begin
      logic [31:0] rd;
      logic        err;
      int          waits;

      areset   = 3'b111;
      psel     = '0;
      penable  = '0;
      pwrite   = '0;
      event_in = '0;
      for (int i = 0; i < 3; i++) begin
         paddr[i]  = '0;
         pwdata[i] = '0;
         pstrb[i]  = '0;
      end
      repeat (3) @(posedge aclk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_pready", {31'b0, pready[i]}, 32'h0);
         chk("rst_pslverr", {31'b0, pslverr[i]}, 32'h0);
         chk("rst_prdata", prdata[i], 32'h0);
         chk("rst_irq", {31'b0, irq[i]}, 32'h0);
         chk("rst_state", {31'b0, dbg_state[i]}, 32'h0);
      end
      areset = 3'b000;
      @(posedge aclk); #1;

      // Full-word writes and readback, zero wait states, back-to-back
      wr_chk(0, 32'h10, 32'hDEADBEEF, 4'hF, 0, "w10");
      wr_chk(0, 32'h14, 32'hDEADAAAA, 4'hF, 0, "w14");
      wr_chk(0, 32'h18, 32'hDEADBBBB, 4'hF, 0, "w18");
      wr_chk(0, 32'h1C, 32'hDEADCCCC, 4'hF, 0, "w1c");
      rd_chk(0, 32'h10, 32'hDEADBEEF, 0, "r10");
      rd_chk(0, 32'h14, 32'hDEADAAAA, 0, "r14");
      rd_chk(0, 32'h18, 32'hDEADBBBB, 0, "r18");
      rd_chk(0, 32'h1C, 32'hDEADCCCC, 0, "r1c");

      // Byte strobes: bytes 0 and 2 only; PSTRB=0 is a no-op
      wr_chk(0, 32'h10, 32'h11223344, 4'b0101, 0, "wstrb");
      rd_chk(0, 32'h10, 32'hDE22BE44, 0, "rstrb");
      wr_chk(0, 32'h14, 32'hFFFFFFFF, 4'b0000, 0, "wnostrb");
      rd_chk(0, 32'h14, 32'hDEADAAAA, 0, "rnostrb");

      // Bad addresses: misaligned, beyond STATUS, below base
      bad_chk(0, 1'b0, 32'h12, "rmis");
      bad_chk(0, 1'b0, 32'h40, "rhigh");
      bad_chk(0, 1'b1, 32'h08, "wlow");
      bad_chk(0, 1'b1, 32'h24, "wabove");
      rd_chk(0, 32'h10, 32'hDE22BE44, 0, "r10_after_bad");
      rd_chk(0, 32'h1C, 32'hDEADCCCC, 0, "r1c_after_bad");
      rd_chk(0, 32'h20, 32'h2, 0, "status_err");
      chk("irq_err", {31'b0, irq[0]}, 32'h1);
      wr_chk(0, 32'h20, 32'h2, 4'hF, 0, "w1c_err");
      rd_chk(0, 32'h20, 32'h0, 0, "status_clr");
      chk("irq_clr", {31'b0, irq[0]}, 32'h0);

      // Event pulse, W1C gated by PSTRB[0], set wins over clear
      event_in[0] = 1'b1;
      @(posedge aclk); #1;
      event_in[0] = 1'b0;
      chk("irq_evt", {31'b0, irq[0]}, 32'h1);
      rd_chk(0, 32'h20, 32'h1, 0, "status_evt");
      wr_chk(0, 32'h20, 32'h3, 4'h0, 0, "w1c_nostrb");
      rd_chk(0, 32'h20, 32'h1, 0, "status_nostrb");
      apb(0, 1'b1, 32'h20, 32'h1, 4'hF, 1'b1, rd, err, waits);
      chk("w1c_evt_err", {31'b0, err}, 32'h0);
      rd_chk(0, 32'h20, 32'h1, 0, "status_setwins");
      wr_chk(0, 32'h20, 32'h1, 4'hF, 0, "w1c_evt");
      rd_chk(0, 32'h20, 32'h0, 0, "status_evt_clr");
      chk("irq_evt_clr", {31'b0, irq[0]}, 32'h0);

      // Three wait states: PREADY low for 3 PENABLE cycles
      wr_chk(1, 32'h14, 32'hCAFEF00D, 4'hF, 3, "ws3_w14");
      rd_chk(1, 32'h14, 32'hCAFEF00D, 3, "ws3_r14");

      // Abort: PSEL dropped during the wait phase
      psel[1]    = 1'b1;
      penable[1] = 1'b0;
      pwrite[1]  = 1'b1;
      paddr[1]   = 32'h14;
      pwdata[1]  = 32'h0;
      pstrb[1]   = 4'hF;
      @(posedge aclk); #1;
      penable[1] = 1'b1;
      chk("abort_pready", {31'b0, pready[1]}, 32'h0);
      @(posedge aclk); #1;
      psel[1]    = 1'b0;
      penable[1] = 1'b0;
      @(posedge aclk); #1;
      chk("abort_state", {31'b0, dbg_state[1]}, 32'h0);
      rd_chk(1, 32'h14, 32'hCAFEF00D, 3, "abort_r14");
      rd_chk(1, 32'h20, 32'h0, 3, "abort_status");

      // Reset mid-access on the two-wait-state instance
      wr_chk(2, 32'h10, 32'h12345678, 4'hF, 2, "ws2_w10");
      bad_chk(2, 1'b0, 32'h40, "ws2_bad");
      chk("ws2_irq", {31'b0, irq[2]}, 32'h1);
      psel[2]    = 1'b1;
      penable[2] = 1'b0;
      pwrite[2]  = 1'b1;
      paddr[2]   = 32'h18;
      pwdata[2]  = 32'hAAAA5555;
      pstrb[2]   = 4'hF;
      @(posedge aclk); #1;
      penable[2] = 1'b1;
      chk("mid_pready", {31'b0, pready[2]}, 32'h0);
      areset[2] = 1'b1;
      @(posedge aclk); #1;
      chk("mrst_pready", {31'b0, pready[2]}, 32'h0);
      chk("mrst_pslverr", {31'b0, pslverr[2]}, 32'h0);
      chk("mrst_prdata", prdata[2], 32'h0);
      chk("mrst_irq", {31'b0, irq[2]}, 32'h0);
      chk("mrst_state", {31'b0, dbg_state[2]}, 32'h0);
      psel[2]    = 1'b0;
      penable[2] = 1'b0;
      areset[2]  = 1'b0;
      @(posedge aclk); #1;
      rd_chk(2, 32'h18, 32'h0, 2, "mrst_r18");
      rd_chk(2, 32'h10, 32'h0, 2, "mrst_r10");
      rd_chk(2, 32'h20, 32'h0, 2, "mrst_status");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
